// File: rtl/pwm_peripheral.sv
// Shared PWM generator and 16-pin output mux. Duty is shadowed at period
// boundaries so register writes never produce truncated or glitched pulses.
module pwm_peripheral #(
   parameter int unsigned CLK_DIV = 3000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  en_reg_out_7_0,
   input  logic [7:0]  en_reg_out_15_8,
   input  logic [7:0]  en_reg_pwm_7_0,
   input  logic [7:0]  en_reg_pwm_15_8,
   input  logic [7:0]  pwm_duty_cycle,
   output logic [15:0] out,
   output logic        period_start
);

   localparam int unsigned PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0] LastPresc = PW'(CLK_DIV - 1);

   logic [PW-1:0] presc_q, presc_d;
   logic [7:0]    count_q, count_d;
   logic [7:0]    duty_q, duty_d;
   logic [15:0]   out_q, out_d;
   logic          pstart_q, pstart_d;
   logic          tick, wrap, pwm_wave;
   logic [15:0]   en_out, en_pwm;

   assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
   assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

   assign tick = (presc_q == LastPresc);
   assign wrap = tick && (count_q == 8'hFF);

   // 0xFF is special-cased so full duty stays high through count 0xFF.
   assign pwm_wave = (duty_q == 8'hFF) ? 1'b1 : (count_q < duty_q);

   always_comb begin
      presc_d  = tick ? '0 : presc_q + PW'(1);
      count_d  = tick ? count_q + 8'd1 : count_q;
      duty_d   = wrap ? pwm_duty_cycle : duty_q;
      pstart_d = wrap;
      out_d    = en_out & (~en_pwm | {16{pwm_wave}});
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q  <= '0;
         count_q  <= 8'h00;
         duty_q   <= 8'h00;
         out_q    <= 16'h0000;
         pstart_q <= 1'b0;
      end else begin
         presc_q  <= presc_d;
         count_q  <= count_d;
         duty_q   <= duty_d;
         out_q    <= out_d;
         pstart_q <= pstart_d;
      end
   end

   assign out          = out_q;
   assign period_start = pstart_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Randomised self-checking bench for pwm_peripheral; the reference model derives
// counter state arithmetically from the number of clock edges since reset.
module tb_pwm_peripheral;

   localparam int unsigned D   = 4;
   localparam int unsigned PER = 256 * D;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] en_out_i = 16'h0000;
   logic [15:0] en_pwm_i = 16'h0000;
   logic [7:0]  duty_i = 8'h00;
   logic [15:0] out;
   logic        period_start;

   int unsigned k = 0;
   logic [7:0]  shadow = 8'h00;
   int          n_vec = 0;
   int          n_err = 0;

   pwm_peripheral #(.CLK_DIV(D)) dut (
      .clk             (clk),
      .rst             (rst),
      .en_reg_out_7_0  (en_out_i[7:0]),
      .en_reg_out_15_8 (en_out_i[15:8]),
      .en_reg_pwm_7_0  (en_pwm_i[7:0]),
      .en_reg_pwm_15_8 (en_pwm_i[15:8]),
      .pwm_duty_cycle  (duty_i),
      .out             (out),
      .period_start    (period_start)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d, t=%0t)", tag, got, exp, k, $time);
      end
   endtask

   // One clock: predict from the state reached after k edges, apply the edge, compare.
   task automatic step();
      int unsigned cnt;
      logic        wave;
      logic [15:0] exp_out;
      cnt     = (k / D) % 256;
      wave    = (shadow == 8'hFF) ? 1'b1 : (cnt < shadow);
      exp_out = en_out_i & (~en_pwm_i | {16{wave}});
      @(posedge clk);
      k++;
      if (k % PER == 0) shadow = duty_i;
      #1;
      check("out", {16'h0, out}, {16'h0, exp_out});
      check("period_start", {31'h0, period_start}, {31'h0, (k % PER == 0)});
   endtask

   task automatic align();
      while (k % PER != 0) step();
   endtask

   task automatic measure_high(input int unsigned change_at, input logic [7:0] new_duty,
                               output int unsigned high);
      high = 0;
      for (int unsigned i = 1; i <= PER; i++) begin
         step();
         if (out[0]) high++;
         if (i == change_at) duty_i = new_duty;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check("reset_async_out", {16'h0, out}, 32'h0);
      check("reset_async_ps", {31'h0, period_start}, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      check("reset_hold_out", {16'h0, out}, 32'h0);
      rst    = 1'b0;
      k      = 0;
      shadow = 8'h00;
   endtask

   initial begin
      logic [7:0]  duties [5];
      int unsigned highs  [5];
      int unsigned h, first_ps;

      duties = '{8'h00, 8'h80, 8'h01, 8'hFE, 8'hFF};
      highs  = '{0, 512, 4, 1016, 1024};

      // Reset with every input at 0xFF; PWM pins must stay low for the first period.
      en_out_i = 16'hFFFF;
      en_pwm_i = 16'hFFFF;
      duty_i   = 8'hFF;
      @(posedge clk);
      #1;
      do_reset();
      first_ps = 0;
      for (int i = 0; i < PER + 8; i++) begin
         step();
         if (period_start && first_ps == 0) first_ps = k;
      end
      check("first_period_start", first_ps, PER);

      // Static drive and output-enable masking.
      en_out_i = 16'h00F0;
      en_pwm_i = 16'h0000;
      step();
      check("static_00F0", {16'h0, out}, 32'h00F0);
      repeat (4) step();
      en_out_i = 16'h0000;
      en_pwm_i = 16'hFFFF;
      step();
      check("masked_0000", {16'h0, out}, 32'h0000);

      // Duty accuracy on pin 0.
      en_out_i = 16'h0001;
      en_pwm_i = 16'h0001;
      for (int i = 0; i < 5; i++) begin
         duty_i = duties[i];
         step();
         align();
         measure_high(0, duties[i], h);
         check($sformatf("duty_%02h_high", duties[i]), h, highs[i]);
      end

      // Mid-period duty change only takes effect from the next period.
      duty_i = 8'h40;
      step();
      align();
      measure_high(64, 8'hC0, h);
      check("glitch_cur_period", h, 256);
      measure_high(0, 8'hC0, h);
      check("glitch_next_period", h, 768);

      // Mixed static/PWM pins at 50% duty.
      en_out_i = 16'hFFFF;
      en_pwm_i = 16'hAAAA;
      duty_i   = 8'h80;
      step();
      align();
      repeat (3) step();
      check("mixed_first_half", {16'h0, out}, 32'hFFFF);
      while ((k % PER) != PER / 2 + 2) step();
      check("mixed_second_half", {16'h0, out}, 32'h5555);
      align();

      // Randomised enables and duty, changed at arbitrary points.
      for (int i = 0; i < 6 * PER; i++) begin
         if ($urandom_range(199) == 0) duty_i = 8'($urandom);
         if ($urandom_range(299) == 0) begin
            en_out_i = 16'($urandom);
            en_pwm_i = 16'($urandom);
         end
         step();
      end

      // Async reset mid-period, then duty shadow must read as zero until the first wrap.
      en_out_i = 16'hFFFF;
      en_pwm_i = 16'h0000;
      align();
      while ((k % PER) != 8'h30 * D) step();
      check("pre_reset_out", {16'h0, out}, 32'hFFFF);
      en_pwm_i = 16'hFFFF;
      duty_i   = 8'h80;
      do_reset();
      first_ps = 0;
      for (int i = 0; i < PER + 4; i++) begin
         step();
         if (period_start && first_ps == 0) first_ps = k;
         if (i == PER / 2) check("post_reset_low", {16'h0, out}, 32'h0);
      end
      check("post_reset_period_start", first_ps, PER);
      repeat (8) step();
      check("post_reset_pwm_high", {16'h0, out}, 32'hFFFF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
